// File: rtl/dm_sba_csrs_if.sv
// DMI request/response channel between the debug transport (master)
// and the debug-module register front-ends (slave).
interface dm_sba_csrs_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_addr;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  modport master (
    output req_valid, req_addr, req_op, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_addr, req_op, req_data, resp_ready,
    output req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/dm_sba_csrs.sv
// System Bus Access register front-end: decodes DMI accesses to sbcs,
// sbaddress0/1 and sbdata0/1 and issues one-cycle triggers to the SBA engine.
module dm_sba_csrs (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dmactive_i,
  dm_sba_csrs_if.slave dmi,
  output logic [63:0] sbaddress_o,
  output logic        sbaddress_write_valid_o,
  output logic        sbreadonaddr_o,
  output logic        sbautoincrement_o,
  output logic        sbreadondata_o,
  output logic [2:0]  sbaccess_o,
  output logic [63:0] sbdata_o,
  output logic        sbdata_write_valid_o,
  output logic        sbdata_read_valid_o,
  input  logic [63:0] sbaddress_i,
  input  logic [63:0] sbdata_i,
  input  logic        sbdata_valid_i,
  input  logic        sbbusy_i,
  input  logic        sberror_valid_i,
  input  logic [2:0]  sberror_i
);

  localparam logic [6:0] ADDR_SBCS  = 7'h38;
  localparam logic [6:0] ADDR_SBA0  = 7'h39;
  localparam logic [6:0] ADDR_SBA1  = 7'h3A;
  localparam logic [6:0] ADDR_SBD0  = 7'h3C;
  localparam logic [6:0] ADDR_SBD1  = 7'h3D;
  localparam logic [1:0] OP_READ    = 2'd1;
  localparam logic [1:0] OP_WRITE   = 2'd2;
  localparam logic [2:0] ACCESS_RST = 3'd2;

  logic [63:0] sbaddress_q;
  logic [63:0] sbdata_q;
  logic        readonaddr_q;
  logic        autoinc_q;
  logic        readondata_q;
  logic [2:0]  sbaccess_q;
  logic        sbbusyerror_q;
  logic [2:0]  sberror_q;
  logic        rd_pending_q;
  logic        addr_trig_q;
  logic        wdata_trig_q;
  logic        rdata_trig_q;
  logic        resp_vld_p1;
  logic [31:0] resp_data_p1;

  logic        accept;
  logic        rd;
  logic        wr;
  logic        busy_eff;
  logic        err;
  logic        wr_sbcs;
  logic        wr_a0;
  logic        wr_a1;
  logic        wr_d0;
  logic        wr_d1;
  logic        rd_d0;
  logic        trig_addr;
  logic        trig_wdata;
  logic        trig_rdata;
  logic        set_busyerr;
  logic [2:0]  sberror_w1c;
  logic [31:0] sbcs_rdata;
  logic [31:0] rdata;
  logic [31:0] wdata;

  assign wdata    = dmi.req_data;
  assign accept   = dmi.req_valid & ~resp_vld_p1;
  assign rd       = accept & (dmi.req_op == OP_READ);
  assign wr       = accept & (dmi.req_op == OP_WRITE);

  // A trigger issued last cycle counts as busy until the engine raises sbbusy_i.
  assign busy_eff = sbbusy_i | addr_trig_q | wdata_trig_q | rdata_trig_q;
  assign err      = sbbusyerror_q | (sberror_q != 3'd0);

  assign wr_sbcs  = wr & (dmi.req_addr == ADDR_SBCS);
  assign wr_a0    = wr & (dmi.req_addr == ADDR_SBA0);
  assign wr_a1    = wr & (dmi.req_addr == ADDR_SBA1);
  assign wr_d0    = wr & (dmi.req_addr == ADDR_SBD0);
  assign wr_d1    = wr & (dmi.req_addr == ADDR_SBD1);
  assign rd_d0    = rd & (dmi.req_addr == ADDR_SBD0);

  assign trig_addr   = wr_a0 & ~busy_eff & readonaddr_q & ~err;
  assign trig_wdata  = wr_d0 & ~busy_eff & ~err;
  assign trig_rdata  = rd_d0 & ~busy_eff & readondata_q & ~err;
  assign set_busyerr = busy_eff & (wr_a0 | wr_a1 | wr_d0 | wr_d1 | rd_d0);
  assign sberror_w1c = sberror_q & ~(wr_sbcs ? wdata[14:12] : 3'd0);

  assign sbcs_rdata = {3'd1, 6'd0, sbbusyerror_q, busy_eff, readonaddr_q, sbaccess_q,
                       autoinc_q, readondata_q, sberror_q, 7'd64, 5'b01111};

  always_comb begin
    rdata = 32'd0;
    if (rd) begin
      case (dmi.req_addr)
        ADDR_SBCS: rdata = sbcs_rdata;
        ADDR_SBA0: rdata = sbaddress_q[31:0];
        ADDR_SBA1: rdata = sbaddress_q[63:32];
        ADDR_SBD0: rdata = sbdata_q[31:0];
        ADDR_SBD1: rdata = sbdata_q[63:32];
        default:   rdata = 32'd0;
      endcase
    end
  end

  // Stage p1: register update, response and trigger pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sbaddress_q   <= '0;
      sbdata_q      <= '0;
      readonaddr_q  <= 1'b0;
      autoinc_q     <= 1'b0;
      readondata_q  <= 1'b0;
      sbaccess_q    <= ACCESS_RST;
      sbbusyerror_q <= 1'b0;
      sberror_q     <= 3'd0;
      rd_pending_q  <= 1'b0;
      addr_trig_q   <= 1'b0;
      wdata_trig_q  <= 1'b0;
      rdata_trig_q  <= 1'b0;
      resp_vld_p1   <= 1'b0;
      resp_data_p1  <= '0;
    end else if (!dmactive_i) begin
      sbaddress_q   <= '0;
      sbdata_q      <= '0;
      readonaddr_q  <= 1'b0;
      autoinc_q     <= 1'b0;
      readondata_q  <= 1'b0;
      sbaccess_q    <= ACCESS_RST;
      sbbusyerror_q <= 1'b0;
      sberror_q     <= 3'd0;
      rd_pending_q  <= 1'b0;
      addr_trig_q   <= 1'b0;
      wdata_trig_q  <= 1'b0;
      rdata_trig_q  <= 1'b0;
      resp_vld_p1   <= 1'b0;
      resp_data_p1  <= '0;
    end else begin
      addr_trig_q  <= trig_addr;
      wdata_trig_q <= trig_wdata;
      rdata_trig_q <= trig_rdata;

      if (resp_vld_p1 && dmi.resp_ready) resp_vld_p1 <= 1'b0;
      if (accept) begin
        resp_vld_p1  <= 1'b1;
        resp_data_p1 <= rdata;
      end

      if (wr_sbcs) begin
        readonaddr_q <= wdata[20];
        sbaccess_q   <= wdata[19:17];
        autoinc_q    <= wdata[16];
        readondata_q <= wdata[15];
      end

      if (set_busyerr)                sbbusyerror_q <= 1'b1;
      else if (wr_sbcs && wdata[22])  sbbusyerror_q <= 1'b0;

      // The first reported error sticks; a same-cycle clear lets a new one in.
      if (sberror_valid_i && (sberror_w1c == 3'd0)) sberror_q <= sberror_i;
      else                                         sberror_q <= sberror_w1c;

      if (wr_a0 && !busy_eff) sbaddress_q[31:0]  <= wdata;
      if (wr_a1 && !busy_eff) sbaddress_q[63:32] <= wdata;
      if (sbdata_valid_i)     sbaddress_q        <= sbaddress_i;

      if (trig_wdata)         sbdata_q[31:0]  <= wdata;
      if (wr_d1 && !busy_eff) sbdata_q[63:32] <= wdata;
      if (sbdata_valid_i && rd_pending_q) sbdata_q <= sbdata_i;

      if (sbdata_valid_i)          rd_pending_q <= 1'b0;
      if (trig_addr || trig_rdata) rd_pending_q <= 1'b1;
    end
  end

  assign dmi.req_ready           = ~resp_vld_p1;
  assign dmi.resp_valid          = resp_vld_p1;
  assign dmi.resp_data           = resp_data_p1;
  assign sbaddress_o             = sbaddress_q;
  assign sbdata_o                = sbdata_q;
  assign sbreadonaddr_o          = readonaddr_q;
  assign sbautoincrement_o       = autoinc_q;
  assign sbreadondata_o          = readondata_q;
  assign sbaccess_o              = sbaccess_q;
  assign sbaddress_write_valid_o = addr_trig_q;
  assign sbdata_write_valid_o    = wdata_trig_q;
  assign sbdata_read_valid_o     = rdata_trig_q;

endmodule
